// File: rtl/banked_lsu_mem_pkg.sv
// Shared types and helpers for the byte-banked LSU data memory.
package lsu_mem_pkg;

  localparam int DATA_W = 32;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'd0,
    SZ_HALF = 2'd1,
    SZ_WORD = 2'd2
  } size_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_READ = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  // Number of bytes touched by an access; the illegal encoding reports 4
  // but is always rejected before it can reach the banks.
  function automatic logic [2:0] size_to_bytes(input logic [1:0] size);
    logic [2:0] n;
    case (size)
      SZ_BYTE: n = 3'd1;
      SZ_HALF: n = 3'd2;
      SZ_WORD: n = 3'd4;
      default: n = 3'd4;
    endcase
    return n;
  endfunction

  // Sign or zero extension of an assembled little-endian load.
  function automatic logic [DATA_W-1:0] extend_load(input logic [DATA_W-1:0] data,
                                                    input logic [1:0]        size,
                                                    input logic              uns);
    logic [DATA_W-1:0] r;
    case (size)
      SZ_BYTE: r = uns ? {24'h000000, data[7:0]} : {{24{data[7]}}, data[7:0]};
      SZ_HALF: r = uns ? {16'h0000, data[15:0]} : {{16{data[15]}}, data[15:0]};
      default: r = data;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/byte_bank_ram.sv
// One byte-wide bank: synchronous write, registered read, no reset on storage.
module byte_bank_ram #(
  parameter int DEPTH = 16384
) (
  input  logic                     clk_i,
  input  logic                     en_i,
  input  logic                     we_i,
  input  logic [$clog2(DEPTH)-1:0] addr_i,
  input  logic [7:0]               wdata_i,
  output logic [7:0]               rdata_o
);

  logic [7:0] mem_q [DEPTH];
  logic [7:0] rdata_q;

  // Single port: a write updates the row, a read captures the row for next cycle.
  always_ff @(posedge clk_i) begin
    if (en_i) begin
      if (we_i) begin
        mem_q[addr_i] <= wdata_i;
      end else begin
        rdata_q <= mem_q[addr_i];
      end
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/banked_lsu_mem.sv
// Byte-banked data memory with valid/ready request and response channels.
// Each access lane k lands in bank (addr+k) mod NUM_BANKS, so any aligned or
// misaligned access needs just one RAM cycle.
module banked_lsu_mem
  import lsu_mem_pkg::*;
#(
  parameter int ADDR_W           = 16,
  parameter int NUM_BANKS        = 4,
  parameter bit ALLOW_MISALIGNED = 1'b1
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_req_valid,
  output logic              o_req_ready,
  input  logic              i_req_we,
  input  logic [1:0]        i_req_size,
  input  logic              i_req_unsigned,
  input  logic [ADDR_W-1:0] i_req_addr,
  input  logic [31:0]       i_req_wdata,
  output logic              o_rsp_valid,
  input  logic              i_rsp_ready,
  output logic [31:0]       o_rsp_rdata,
  output logic              o_rsp_err
);

  localparam int BW    = $clog2(NUM_BANKS);
  localparam int RW    = ADDR_W - BW;
  localparam int DEPTH = 2 ** RW;

  state_e            state_q, state_d;
  logic [31:0]       rdata_q, rdata_d;
  logic              err_q, err_d;
  logic [BW-1:0]     addr_lo_q;
  logic [1:0]        size_q;
  logic              uns_q;

  logic [2:0]        nbytes_s;
  logic [ADDR_W:0]   last_s;
  logic              size_err_s, cross_err_s, align_err_s, req_err_s;
  logic              accept_s;
  logic [7:0]        bank_rd_s [NUM_BANKS];
  logic [31:0]       raw_s;

  assign accept_s    = i_req_valid & o_req_ready;
  assign nbytes_s    = size_to_bytes(i_req_size);
  // Last byte computed one bit wider so a top-of-memory crossing is visible.
  assign last_s      = {1'b0, i_req_addr} + (ADDR_W+1)'(nbytes_s) - (ADDR_W+1)'(1);
  assign size_err_s  = (i_req_size == 2'd3);
  assign cross_err_s = last_s[ADDR_W];
  assign align_err_s = !ALLOW_MISALIGNED &&
                       ((i_req_addr[1:0] & (nbytes_s[1:0] - 2'd1)) != 2'd0);
  assign req_err_s   = size_err_s | cross_err_s | align_err_s;

  // Per-bank lane decode: which access byte (if any) this bank serves.
  for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
    logic [BW-1:0] lane_s;
    logic [1:0]    lane2_s;
    logic          act_s;
    logic [RW-1:0] row_s;

    assign lane_s  = BW'(b) - i_req_addr[BW-1:0];
    assign lane2_s = lane_s[1:0];
    assign act_s   = int'(lane_s) < int'(nbytes_s);
    // Banks below the start bank are reached only after wrapping to the next row.
    assign row_s   = i_req_addr[ADDR_W-1:BW] + RW'(BW'(b) < i_req_addr[BW-1:0]);

    byte_bank_ram #(.DEPTH(DEPTH)) u_ram (
      .clk_i   (i_clk),
      .en_i    (accept_s & act_s & ~req_err_s),
      .we_i    (i_req_we),
      .addr_i  (row_s),
      .wdata_i (i_req_wdata[{lane2_s, 3'b000} +: 8]),
      .rdata_o (bank_rd_s[b])
    );
  end

  // Rotate bank outputs back into little-endian lane order.
  always_comb begin
    raw_s = 32'h0000_0000;
    for (int k = 0; k < 4; k++) begin
      raw_s[8*k +: 8] = bank_rd_s[addr_lo_q + BW'(k)];
    end
  end

  // Next-state and response data selection.
  always_comb begin
    state_d = state_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    case (state_q)
      ST_IDLE: begin
        if (accept_s) begin
          rdata_d = 32'h0000_0000;
          err_d   = req_err_s;
          if (req_err_s || i_req_we) begin
            state_d = ST_RESP;
          end else begin
            state_d = ST_READ;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_READ: begin
        rdata_d = extend_load(raw_s, size_q, uns_q);
        state_d = ST_RESP;
      end
      ST_RESP: begin
        if (i_rsp_ready) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_RESP;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // FSM state and response registers; reset drops any transaction in flight.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state_q <= ST_IDLE;
      rdata_q <= 32'h0000_0000;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  // Capture load shape at accept for use during the READ cycle.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      addr_lo_q <= '0;
      size_q    <= 2'd0;
      uns_q     <= 1'b0;
    end else if (accept_s) begin
      addr_lo_q <= i_req_addr[BW-1:0];
      size_q    <= i_req_size;
      uns_q     <= i_req_unsigned;
    end
  end

  assign o_req_ready = (state_q == ST_IDLE);
  assign o_rsp_valid = (state_q == ST_RESP);
  assign o_rsp_rdata = rdata_q;
  assign o_rsp_err   = err_q;

endmodule

// File: doc/banked_lsu_mem.md
Name: banked_lsu_mem

Overview:
- Parametrised byte-banked data memory with a valid/ready request/response front end for the pipelined core's MEM stage.
- Any byte, half or word access is split across NUM_BANKS byte-wide banks, so misaligned accesses complete in one RAM cycle.
- Sub-word accesses get byte-lane steering, and loads get sign/zero extension.
- Range and size errors are reported on the response channel.

Parameters:
ADDR_W, 16, byte-address width; total capacity 2**ADDR_W bytes
NUM_BANKS, 4, byte banks; power of two, >= 4
ALLOW_MISALIGNED, 1, 1: misaligned half/word allowed; 0: flagged as error

Ports:
i_clk  in  1  clock, rising edge
i_reset  in  1  asynchronous reset, active-high
i_req_valid  in  1  request valid
o_req_ready  out  1  request accepted when valid&ready
i_req_we  in  1  1 = store, 0 = load
i_req_size  in  2  0 byte, 1 half, 2 word, 3 illegal
i_req_unsigned  in  1  loads: 1 zero-extend, 0 sign-extend
i_req_addr  in  ADDR_W  byte address
i_req_wdata  in  32  store data, little-endian, LSBs used for byte/half
o_rsp_valid  out  1  response valid
i_rsp_ready  in  1  response consumed when valid&ready
o_rsp_rdata  out  32  extended load data; 0 for stores and errors
o_rsp_err  out  1  access rejected; memory unchanged

Behaviour:
- Reset (async, i_reset=1): state IDLE, o_rsp_valid=0, o_rsp_rdata=0, o_rsp_err=0. o_req_ready follows state, so it is 1 after reset. Bank contents are not reset.
- Requests to reset mid-operation are dropped: no partial write is completed after reset deasserts, and no response is issued.
- FSM states:
  - IDLE: o_req_ready=1. On accept, a store or error goes to RESP; a load goes to READ.
  - READ: one cycle. Bank outputs are assembled and extended, then registered. Next state RESP.
  - RESP: o_rsp_valid=1, outputs held stable. On i_rsp_ready go to IDLE. There is no IDLE bypass.
- Latency (accept in cycle 0): store/error response in cycle 1; load response in cycle 2. Peak throughput: one store per 2 cycles, one load per 3 cycles.
- Address mapping: byte k of the access (k = 0..n-1, n = 1/2/4) goes to address a = i_req_addr + k.
  - Bank = a mod NUM_BANKS; row = a / NUM_BANKS.
  - Lane k maps to byte k of wdata/rdata (little-endian).
- Stores: bank writes occur on the accept edge. Only the n addressed banks are written; the others are untouched.
- Error conditions, evaluated at accept. On error: no write, rdata=0, err=1.
  - size == 3.
  - Access crosses the top of memory: i_req_addr + n - 1 > 2**ADDR_W - 1. No wrap-around to address 0.
  - ALLOW_MISALIGNED=0 and the address is not a multiple of n.
- Load extension: byte → bit 7 replicated to [31:8] if signed, else zero; half → bit 15 replicated to [31:16], else zero.
- Backpressure: while RESP and i_rsp_ready=0, rdata and err stay constant and o_req_ready=0.
- Ordering: a load issued after a store always observes that store, since the store writes before its response.

Decomposition:
- Package lsu_mem_pkg:
  - size enum (SZ_BYTE, SZ_HALF, SZ_WORD).
  - FSM state enum (ST_IDLE, ST_READ, ST_RESP).
  - Function size_to_bytes.
  - Function extend_load(data, size, unsigned).
- Sub-module byte_bank_ram: parameter DEPTH, single-port 8-bit, synchronous write, registered read (1-cycle). Instantiated NUM_BANKS times via generate.
- Lane rotation and error detection stay in the top level.

Test Plan:
- Store word 0xDEADBEEF @0x0001; load word @0x0001 → rdata 0xDEADBEEF, err 0. Load response arrives exactly 2 cycles after accept.
- After the above: load byte signed @0x0002 → 0xFFFFFFBE; unsigned @0x0002 → 0x000000BE; half signed @0x0003 → 0xFFFFDEAD.
- Store word 0x11223344 @0x0000; store byte 0x55 @0x0002; load word @0x0000 → 0x11553344, showing the other banks are untouched.
- Word store @0xFFFE → err 1, rdata 0, response in cycle 1. Load word @0xFFFC → err 0. With ALLOW_MISALIGNED=0, load half @0x0001 → err 1. Any access with size=3 → err 1.
- Backpressure: hold i_rsp_ready=0 for 3 cycles on a load response → o_rsp_valid, rdata and err stable; o_req_ready=0; a pending i_req_valid is not accepted until the cycle after the handshake.
- Reset in READ: assert i_reset asynchronously → o_rsp_valid=0 immediately, state IDLE; a store to the same address from before the reset is still readable afterwards.
